octant_reduce: RTL and testbench

OCTANT_REDUCE -- requirements
Module: octant_reduce

---
 rtl/octant_pkg.sv | 15 +
 rtl/seq_divider.sv | 51 +++++
 rtl/octant_reduce.sv | 83 ++++++++
 tb/tb_octant_reduce.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/octant_pkg.sv
// Shared types and constants for the octant reduction block.
package octant_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions inside case_flag
  localparam int unsigned FLAG_XNEG = 2;
  localparam int unsigned FLAG_YNEG = 1;
  localparam int unsigned FLAG_SWAP = 0;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: quo = floor(num * 2^F / den), one quotient bit per cycle, MSB first.
// Requires num <= den; num == den yields all ones, den == 0 yields zero.
module seq_divider #(
  parameter int unsigned W = 8,
  parameter int unsigned F = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic [F-1:0] quo,
  output logic         done_c
);

  localparam int unsigned CW = $clog2(F);

  logic [W-1:0]  rem;
  logic [W-1:0]  den_q;
  logic [CW-1:0] cnt;
  logic          busy;
  logic [W:0]    shifted;
  logic          take;

  // Remainder never exceeds den, so the shifted value always fits in W+1 bits
  assign shifted = {rem, 1'b0};
  assign take    = (den_q != '0) && (shifted >= {1'b0, den_q});
  assign done_c  = busy && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      den_q <= '0;
      quo   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      rem   <= num;
      den_q <= den;
      quo   <= '0;
      cnt   <= CW'(F - 1);
      busy  <= 1'b1;
    end else if (busy) begin
      rem <= take ? W'(shifted - {1'b0, den_q}) : W'(shifted);
      quo <= {quo[F-2:0], take};
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/octant_reduce.sv
// Folds a complex sample into the first octant: octant code plus min/max ratio
// for a downstream atan polynomial. Fixed latency, valid/ready on both sides.
module octant_reduce
  import octant_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned F = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         val_i,
  output logic         ready_o,
  input  logic [W-1:0] real_i,
  input  logic [W-1:0] imag_i,
  output logic         val_o,
  input  logic         ready_i,
  output logic [F-1:0] into_atan_poly,
  output logic [2:0]   case_flag
);

  state_t       state_q, state_d;
  logic         accept;
  logic         div_done;
  logic [W-1:0] ax, ay, mn, mx;
  logic         swap;
  logic [2:0]   flag_d;

  // Magnitudes as unsigned W-bit values; the most negative input maps to 2^(W-1)
  assign ax   = real_i[W-1] ? W'(W'(0) - real_i) : real_i;
  assign ay   = imag_i[W-1] ? W'(W'(0) - imag_i) : imag_i;
  assign swap = ay > ax;
  assign mn   = swap ? ax : ay;
  assign mx   = swap ? ay : ax;

  assign accept = val_i && ready_o;

  always_comb begin
    flag_d            = '0;
    flag_d[FLAG_XNEG] = real_i[W-1];
    flag_d[FLAG_YNEG] = imag_i[W-1];
    flag_d[FLAG_SWAP] = swap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DIV;
      DIV:     if (div_done) state_d = DONE;
      DONE:    if (ready_i) state_d = val_i ? DIV : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    val_o   = (state_q == DONE);
    ready_o = (state_q == IDLE) || ((state_q == DONE) && ready_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      case_flag <= '0;
    else if (accept) case_flag <= flag_d;
  end

  // The divider's quotient register is the ratio output; it holds once division ends
  seq_divider #(
    .W (W),
    .F (F)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept),
    .num    (mn),
    .den    (mx),
    .quo    (into_atan_poly),
    .done_c (div_done)
  );

endmodule

// File: tb/tb_octant_reduce.sv
// Directed self-checking bench for octant_reduce (W=8, F=8) with hand-computed vectors.
module tb_octant_reduce;

  localparam int unsigned W = 8;
  localparam int unsigned F = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         val_i;
  logic         ready_o;
  logic [W-1:0] real_i;
  logic [W-1:0] imag_i;
  logic         val_o;
  logic         ready_i;
  logic [F-1:0] into_atan_poly;
  logic [2:0]   case_flag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] re;
    logic [7:0] im;
    logic [2:0] flag;
    logic [7:0] q;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  octant_reduce #(.W(W), .F(F)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .val_i          (val_i),
    .ready_o        (ready_o),
    .real_i         (real_i),
    .imag_i         (imag_i),
    .val_o          (val_o),
    .ready_i        (ready_i),
    .into_atan_poly (into_atan_poly),
    .case_flag      (case_flag)
  );

  // Edges after the accept edge until val_o is seen; 8 means F+1 cycles counting the accept cycle
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!val_o && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; val_i = 1'b0; ready_i = 1'b1; real_i = 8'h5A; imag_i = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    checks++; if (val_o !== 1'b0) begin errors++; $display("FAIL reset_val: got %b expected 0", val_o); end
    checks++; if (into_atan_poly !== 8'h00) begin errors++; $display("FAIL reset_ratio: got %h expected 00", into_atan_poly); end
    checks++; if (case_flag !== 3'b000) begin errors++; $display("FAIL reset_flag: got %b expected 000", case_flag); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", ready_o); end
  endtask

  // One isolated transaction with ready_i high; starts and ends at posedge+1 in IDLE
  task automatic run_one(input vec_t v, input int idx);
    int cyc;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL idle_ready[%0d]: got %b expected 1", idx, ready_o); end
    val_i = 1'b1; real_i = v.re; imag_i = v.im; ready_i = 1'b1;
    @(posedge clk); #1;
    val_i = 1'b0; real_i = 8'hC3; imag_i = 8'h3C;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL div_ready[%0d]: got %b expected 0", idx, ready_o); end
    wait_valid(cyc);
    checks++; if (cyc !== 8) begin errors++; $display("FAIL latency[%0d]: got %0d expected 8", idx, cyc); end
    checks++; if (case_flag !== v.flag) begin errors++; $display("FAIL flag[%0d]: got %b expected %b", idx, case_flag, v.flag); end
    checks++; if (into_atan_poly !== v.q) begin errors++; $display("FAIL ratio[%0d]: got %h expected %h", idx, into_atan_poly, v.q); end
    @(posedge clk); #1;
    checks++; if (val_o !== 1'b0) begin errors++; $display("FAIL val_drop[%0d]: got %b expected 0", idx, val_o); end
  endtask

  task automatic test_vectors();
    for (int i = 0; i < 8; i++) run_one(vecs[i], i);
  endtask

  task automatic test_backpressure();
    int cyc;
    val_i = 1'b1; real_i = vecs[5].re; imag_i = vecs[5].im; ready_i = 1'b0;
    @(posedge clk); #1;
    val_i = 1'b0;
    wait_valid(cyc);
    checks++; if (cyc !== 8) begin errors++; $display("FAIL bp_latency: got %0d expected 8", cyc); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      real_i = 8'(k * 37); imag_i = 8'(k * 91);
      checks++; if (val_o !== 1'b1 || ready_o !== 1'b0) begin errors++; $display("FAIL bp_hold_hs[%0d]: got val %b ready %b expected 1 0", k, val_o, ready_o); end
      checks++; if (into_atan_poly !== 8'hB6 || case_flag !== 3'b001) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h/%b expected b6/001", k, into_atan_poly, case_flag); end
    end
    ready_i = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", ready_o); end
    @(posedge clk); #1;
    checks++; if (val_o !== 1'b0) begin errors++; $display("FAIL bp_single_delivery: got %b expected 0", val_o); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    val_i = 1'b1; ready_i = 1'b1; real_i = vecs[0].re; imag_i = vecs[0].im;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      if (i + 1 < 6) begin real_i = vecs[i+1].re; imag_i = vecs[i+1].im; end
      else val_i = 1'b0;
      wait_valid(cyc);
      checks++; if (cyc !== 8) begin errors++; $display("FAIL b2b_period[%0d]: got %0d expected 8", i, cyc); end
      checks++; if (case_flag !== vecs[i].flag || into_atan_poly !== vecs[i].q) begin
        errors++; $display("FAIL b2b_data[%0d]: got %b/%h expected %b/%h", i, case_flag, into_atan_poly, vecs[i].flag, vecs[i].q);
      end
      @(posedge clk); #1;
    end
    checks++; if (val_o !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", val_o); end
  endtask

  task automatic test_reset_mid_div();
    int seen;
    val_i = 1'b1; ready_i = 1'b1; real_i = vecs[7].re; imag_i = vecs[7].im;
    @(posedge clk); #1;
    val_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checks++; if (val_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL midrst_hs: got val %b ready %b expected 0 1", val_o, ready_o); end
    checks++; if (into_atan_poly !== 8'h00 || case_flag !== 3'b000) begin errors++; $display("FAIL midrst_data: got %h/%b expected 00/000", into_atan_poly, case_flag); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (val_o) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d valid cycles expected 0", seen); end
    run_one(vecs[1], 101);
  endtask

  initial begin
    vecs[0] = '{re: 8'h03, im: 8'h01, flag: 3'b000, q: 8'h55};
    vecs[1] = '{re: 8'hFC, im: 8'h08, flag: 3'b101, q: 8'h80};
    vecs[2] = '{re: 8'h80, im: 8'h80, flag: 3'b110, q: 8'hFF};
    vecs[3] = '{re: 8'h00, im: 8'h00, flag: 3'b000, q: 8'h00};
    vecs[4] = '{re: 8'h01, im: 8'hFD, flag: 3'b011, q: 8'h55};
    vecs[5] = '{re: 8'h05, im: 8'h07, flag: 3'b001, q: 8'hB6};
    vecs[6] = '{re: 8'hFF, im: 8'h7F, flag: 3'b101, q: 8'h02};
    vecs[7] = '{re: 8'h7F, im: 8'h80, flag: 3'b011, q: 8'hFE};

    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_div();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
